hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the five-stage processor pipeline. It sits beside the decode stage. It tracks the destination register of every in-flight instruction from EX through WB in a shift-register scoreboard. Each cycle it tells decode whether to stall and which later stage, if any, should supply each source operand. The register count, pipeline depth and producer-ready stages are all parameters, and the block also supports an external hold, flush squash and a stall performance counter.

## Interface
- REG_COUNT, 16: architectural registers; AW = $clog2(REG_COUNT).
- STAGES, 3: tracked stages after ID (1 = EX, 2 = MEM, 3 = WB).
- ALU_READY, 1: first stage whose ALU result is forwardable.
- LOAD_READY, 2: first stage whose load data is forwardable; must be ≥ ALU_READY and ≤ STAGES.
- ZERO_REG, 1: when 1, register 0 never creates a hazard.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- id_valid  in  1  decode holds a real instruction.
- id_src1, id_src2  in  AW  source register numbers.
- id_src1_used, id_src2_used  in  1  the source is actually read.
- id_we  in  1  the instruction writes a register.
- id_dest  in  AW  destination register.
- id_is_load  in  1  the result comes from memory.
- flush  in  1  squash the instruction in ID (branch taken in EX).
- hold  in  1  external freeze of the whole pipeline.
- stall  out  1  decode must repeat the current instruction.
- fwd1_sel, fwd2_sel  out  $clog2(STAGES+1)  0 = register file; k = forward from stage k.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Scoreboard: entries 1..STAGES, each holding {valid, dest, is_load}. Entry k is the instruction that left ID k cycles ago, counting only advancing cycles.
- Match for source s: the entry is valid, its dest equals s, s is used, and id_valid = 1. When ZERO_REG = 1 and s = 0, there is never a match.
- The youngest match (smallest k) decides the result; older matches are ignored.
- The matched entry is ready when k ≥ (is_load ? LOAD_READY : ALU_READY).
- If the match is ready, fwd_sel = k. If it is not ready, stall = 1 and fwd_sel = 0.
- If there is no match, fwd_sel = 0.
- stall = (not-ready match on src1 or src2) AND NOT flush.
- Advance happens when hold = 0:
  - Entry k+1 takes entry k; entry STAGES is dropped. The register file writes in WB and bypasses a same-cycle read internally.
  - Entry 1 takes the ID instruction when id_valid & id_we & ~stall & ~flush. Otherwise entry 1 gets a bubble (valid = 0).
- hold = 1: no state changes, stall_cnt does not increment, and the outputs are still computed from the frozen state.
- flush is honoured only when hold = 0.
- stall_cnt increments when stall & ~hold, and saturates at all-ones.

## Timing
- stall and fwd_sel are combinational from the registered scoreboard and the current ID inputs, so they are valid within the same cycle.
- The scoreboard and stall_cnt update on the rising edge of clk.
- Reset: all entries invalid and stall_cnt = 0, so stall = 0 and fwd_sel = 0 in the first cycle after reset.
- A reset in the middle of a stall clears it on the next edge; no hazard state survives reset.
- Load-use with defaults: exactly one stall cycle, then fwd_sel = 2.
- Back-to-back ALU use: zero stalls, fwd_sel = 1.
- Simultaneous flush and not-ready hazard: stall = 0 and a bubble is inserted.
- rst has priority over hold.

## Structure
- The shared package proc_pkg holds:
  - REG_COUNT and AW;
  - the sb_entry_t struct {valid, dest, is_load};
  - the FWD_RF = 0 encoding constant.
- Sub-module hazard_match, instantiated once per source operand:
  - combinational;
  - inputs are the scoreboard array, the source register and the used bit;
  - outputs are the forward select and the not-ready flag.
- The top level holds the shift register, the advance logic and the counter.

## Test plan
- Reset: hold rst for 2 cycles → stall = 0, fwd1_sel = fwd2_sel = 0, stall_cnt = 0.
- ALU chain: issue a write to r3, then an instruction reading r3 as src1 → fwd1_sel = 1 and stall = 0. One cycle later, a reader of r3 → fwd1_sel = 2.
- Load-use: load to r5, then an instruction reading r5 as src2 → stall = 1 for one cycle. The next cycle gives fwd2_sel = 2 and stall = 0, and stall_cnt = 1.
- Youngest wins: r4 written at stages 1 and 3, then a reader of r4 → fwd1_sel = 1.
- ZERO_REG: write r0, then read r0 → fwd1_sel = 0 and stall = 0. With ZERO_REG = 0 → fwd1_sel = 1.
- Flush and hold:
  - A load-use pending together with flush = 1 → stall = 0 and entry 1 becomes invalid.
  - hold = 1 for 3 cycles → the scoreboard and stall_cnt are unchanged.
  - stall_cnt at all-ones stays at all-ones.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: register file geometry, scoreboard entry
// layout and the forward-select encoding for "read the register file".
package proc_pkg;

  localparam int unsigned REG_COUNT = 16;
  localparam int unsigned AW        = $clog2(REG_COUNT);

  // Forward select value meaning "no bypass, use the register file"
  localparam int unsigned FWD_RF = 0;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] dest;
    logic          is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Per-operand hazard resolution: finds the youngest scoreboard entry that
// writes the source register and decides between forwarding and stalling.
module hazard_match
  import proc_pkg::*;
#(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned ALU_READY  = 1,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned ZERO_REG   = 1,
  localparam int unsigned SW        = $clog2(STAGES + 1)
) (
  input  sb_entry_t       sb [1:STAGES],
  input  logic            id_valid,
  input  logic [AW-1:0]   src,
  input  logic            used,
  output logic [SW-1:0]   fwd_sel,
  output logic            not_ready
);

  logic active;

  // Scan oldest to youngest so the youngest match is the last one to assign
  always_comb begin
    fwd_sel   = SW'(FWD_RF);
    not_ready = 1'b0;
    active    = id_valid && used && !((ZERO_REG != 0) && (src == '0));
    for (int unsigned k = STAGES; k >= 1; k--) begin
      if (active && sb[k].valid && (sb[k].dest == src)) begin
        if (k >= (sb[k].is_load ? LOAD_READY : ALU_READY)) begin
          fwd_sel   = SW'(k);
          not_ready = 1'b0;
        end else begin
          fwd_sel   = SW'(FWD_RF);
          not_ready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside decode. Tracks the destination of
// every in-flight instruction in a shift-register scoreboard (entry k = k
// advancing cycles after ID), drives stall / forward selects and counts
// stall cycles. REG_COUNT must not exceed proc_pkg::REG_COUNT; narrower
// register numbers are zero-extended into the scoreboard.
module hazard_scoreboard
  import proc_pkg::*;
#(
  parameter int unsigned REG_COUNT  = proc_pkg::REG_COUNT,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned ALU_READY  = 1,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [$clog2(REG_COUNT)-1:0]   id_src1,
  input  logic [$clog2(REG_COUNT)-1:0]   id_src2,
  input  logic                           id_src1_used,
  input  logic                           id_src2_used,
  input  logic                           id_we,
  input  logic [$clog2(REG_COUNT)-1:0]   id_dest,
  input  logic                           id_is_load,
  input  logic                           flush,
  input  logic                           hold,
  output logic                           stall,
  output logic [$clog2(STAGES+1)-1:0]    fwd1_sel,
  output logic [$clog2(STAGES+1)-1:0]    fwd2_sel,
  output logic [CNT_W-1:0]               stall_cnt
);

  sb_entry_t        sb_q [1:STAGES];
  sb_entry_t        sb_d [1:STAGES];
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             nr1;
  logic             nr2;

  hazard_match #(
    .STAGES     (STAGES),
    .ALU_READY  (ALU_READY),
    .LOAD_READY (LOAD_READY),
    .ZERO_REG   (ZERO_REG)
  ) u_match1 (
    .sb        (sb_q),
    .id_valid  (id_valid),
    .src       (AW'(id_src1)),
    .used      (id_src1_used),
    .fwd_sel   (fwd1_sel),
    .not_ready (nr1)
  );

  hazard_match #(
    .STAGES     (STAGES),
    .ALU_READY  (ALU_READY),
    .LOAD_READY (LOAD_READY),
    .ZERO_REG   (ZERO_REG)
  ) u_match2 (
    .sb        (sb_q),
    .id_valid  (id_valid),
    .src       (AW'(id_src2)),
    .used      (id_src2_used),
    .fwd_sel   (fwd2_sel),
    .not_ready (nr2)
  );

  // A flush squashes the decode instruction, so it never needs to wait
  always_comb begin
    stall = (nr1 | nr2) & ~flush;
  end

  // Next scoreboard and counter: shift on advancing cycles, freeze on hold
  always_comb begin
    sb_d        = sb_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      for (int unsigned k = STAGES; k >= 2; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[1].valid   = id_valid & id_we & ~stall & ~flush;
      sb_d[1].dest    = AW'(id_dest);
      sb_d[1].is_load = id_is_load;
      if (stall && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset taking priority over hold
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 1; k <= STAGES; k++) begin
        sb_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a history-based reference model. A second instance exercises
// ZERO_REG = 0 and a narrow, quickly saturating stall counter.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_src1_used, id_src2_used, id_we, id_is_load;
  logic       flush, hold;
  logic [3:0] id_src1, id_src2, id_dest;

  logic        stall_a, stall_b;
  logic [1:0]  f1_a, f2_a, f1_b, f2_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  hazard_scoreboard dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .id_we(id_we), .id_dest(id_dest), .id_is_load(id_is_load),
    .flush(flush), .hold(hold),
    .stall(stall_a), .fwd1_sel(f1_a), .fwd2_sel(f2_a), .stall_cnt(cnt_a)
  );

  hazard_scoreboard #(.ZERO_REG(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .id_we(id_we), .id_dest(id_dest), .id_is_load(id_is_load),
    .flush(flush), .hold(hold),
    .stall(stall_b), .fwd1_sel(f1_b), .fwd2_sel(f2_b), .stall_cnt(cnt_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: list of the last three issued slots, index 0 = age 1
  typedef struct { bit v; int dest; bit ld; } ins_t;
  typedef ins_t hist_t [3];

  hist_t hist_a, hist_b;
  int    mcnt_a, mcnt_b;

  function automatic void lookup(input hist_t h, input int src, input bit used,
                                 input bit zr, output int sel, output bit nr);
    sel = 0;
    nr  = 0;
    if (!id_valid || !used || (zr && src == 0)) return;
    for (int age = 1; age <= 3; age++) begin
      if (h[age-1].v && h[age-1].dest == src) begin
        if (age >= (h[age-1].ld ? 2 : 1)) sel = age;
        else nr = 1;
        return;
      end
    end
  endfunction

  function automatic void predict(input hist_t h, input bit zr,
                                  output int s1, output int s2, output bit st);
    bit n1, n2;
    lookup(h, int'(id_src1), id_src1_used, zr, s1, n1);
    lookup(h, int'(id_src2), id_src2_used, zr, s2, n2);
    st = (n1 || n2) && !flush;
  endfunction

  function automatic void model_next(input hist_t h, input bit zr, input int cnt,
                                     input int cmax, output hist_t nh, output int ncnt);
    int s1, s2;
    bit st;
    nh   = h;
    ncnt = cnt;
    if (rst) begin
      for (int i = 0; i < 3; i++) nh[i] = '{v: 0, dest: 0, ld: 0};
      ncnt = 0;
    end else if (!hold) begin
      predict(h, zr, s1, s2, st);
      nh[2] = h[1];
      nh[1] = h[0];
      nh[0] = '{v: id_valid && id_we && !st && !flush, dest: int'(id_dest), ld: id_is_load};
      if (st && cnt < cmax) ncnt = cnt + 1;
    end
  endfunction

  task automatic step();
    hist_t na, nb;
    int ca, cb;
    model_next(hist_a, 1'b1, mcnt_a, 65535, na, ca);
    model_next(hist_b, 1'b0, mcnt_b, 7, nb, cb);
    @(posedge clk);
    hist_a = na; hist_b = nb; mcnt_a = ca; mcnt_b = cb;
    #1;
  endtask

  task automatic drive(bit v, int s1, bit u1, int s2, bit u2, bit we, int d,
                       bit ld, bit fl, bit hd);
    id_valid = v; id_src1 = 4'(s1); id_src1_used = u1;
    id_src2 = 4'(s2); id_src2_used = u2; id_we = we; id_dest = 4'(d);
    id_is_load = ld; flush = fl; hold = hd;
  endtask

  task automatic idle(int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    drive(1, 3, 1, 5, 1, 1, 3, 0, 0, 0);
    #1;
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_a); end
    checks++; if (f1_a !== 2'd0) begin failures++; $display("FAIL reset_fwd1 got=%0d exp=0", f1_a); end
    checks++; if (f2_a !== 2'd0) begin failures++; $display("FAIL reset_fwd2 got=%0d exp=0", f2_a); end
    checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
    idle(3);
  endtask

  task automatic test_alu_chain();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); step();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (f1_a !== 2'd1) begin failures++; $display("FAIL alu_fwd1_stage1 got=%0d exp=1", f1_a); end
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL alu_no_stall got=%0b exp=0", stall_a); end
    step();
    #1;
    checks++; if (f1_a !== 2'd2) begin failures++; $display("FAIL alu_fwd1_stage2 got=%0d exp=2", f1_a); end
    idle(3);
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); step();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); #1;
    checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL load_use_stall got=%0b exp=1", stall_a); end
    checks++; if (f2_a !== 2'd0) begin failures++; $display("FAIL load_use_fwd2_rf got=%0d exp=0", f2_a); end
    step();
    #1;
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL load_use_release got=%0b exp=0", stall_a); end
    checks++; if (f2_a !== 2'd2) begin failures++; $display("FAIL load_use_fwd2 got=%0d exp=2", f2_a); end
    checks++; if (cnt_a !== 16'd1) begin failures++; $display("FAIL load_use_cnt got=%0d exp=1", cnt_a); end
    idle(3);
  endtask

  task automatic test_youngest();
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); step();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (f1_a !== 2'd1) begin failures++; $display("FAIL youngest_fwd1 got=%0d exp=1", f1_a); end
    idle(3);
  endtask

  task automatic test_zero_reg();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); step();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (f1_a !== 2'd0) begin failures++; $display("FAIL zero_reg_fwd1 got=%0d exp=0", f1_a); end
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL zero_reg_stall got=%0b exp=0", stall_a); end
    checks++; if (f1_b !== 2'd1) begin failures++; $display("FAIL no_zero_reg_fwd1 got=%0d exp=1", f1_b); end
    idle(3);
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); step();
    drive(1, 0, 0, 5, 1, 1, 6, 0, 1, 0); #1;
    checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", stall_a); end
    step();
    drive(1, 6, 1, 5, 1, 0, 0, 0, 0, 0); #1;
    checks++; if (f1_a !== 2'd0) begin failures++; $display("FAIL flush_bubble_fwd1 got=%0d exp=0", f1_a); end
    checks++; if (f2_a !== 2'd2) begin failures++; $display("FAIL flush_load_fwd2 got=%0d exp=2", f2_a); end
    idle(3);
  endtask

  task automatic test_hold();
    int c0;
    c0 = mcnt_a;
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); step();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL hold_stall cyc=%0d got=%0b exp=1", i, stall_a); end
      checks++; if (cnt_a !== 16'(c0)) begin failures++; $display("FAIL hold_cnt cyc=%0d got=%0d exp=%0d", i, cnt_a, c0); end
      step();
    end
    hold = 1'b0; #1;
    checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL hold_release_stall got=%0b exp=1", stall_a); end
    step();
    #1;
    checks++; if (f2_a !== 2'd2) begin failures++; $display("FAIL hold_after_fwd2 got=%0d exp=2", f2_a); end
    checks++; if (cnt_a !== 16'(c0 + 1)) begin failures++; $display("FAIL hold_after_cnt got=%0d exp=%0d", cnt_a, c0 + 1); end
    idle(3);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); step();
      drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); step(); step();
    end
    #1;
    checks++; if (cnt_b !== 3'd7) begin failures++; $display("FAIL sat_cnt got=%0d exp=7", cnt_b); end
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); step();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); #1;
    checks++; if (stall_b !== 1'b1) begin failures++; $display("FAIL sat_stall got=%0b exp=1", stall_b); end
    step();
    #1;
    checks++; if (cnt_b !== 3'd7) begin failures++; $display("FAIL sat_cnt_hold got=%0d exp=7", cnt_b); end
    idle(3);
  endtask

  task automatic test_random();
    int s1, s2;
    bit st;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(63) == 0);
      drive($urandom_range(7) != 0, $urandom_range(3), $urandom_range(1),
            $urandom_range(3), $urandom_range(1), $urandom_range(3) != 0,
            $urandom_range(3), $urandom_range(2) == 0,
            $urandom_range(7) == 0, $urandom_range(7) == 0);
      #1;
      predict(hist_a, 1'b1, s1, s2, st);
      checks++; if (stall_a !== st) begin failures++; $display("FAIL rnd_stall_a n=%0d got=%0b exp=%0b", n, stall_a, st); end
      checks++; if (f1_a !== 2'(s1)) begin failures++; $display("FAIL rnd_fwd1_a n=%0d got=%0d exp=%0d", n, f1_a, s1); end
      checks++; if (f2_a !== 2'(s2)) begin failures++; $display("FAIL rnd_fwd2_a n=%0d got=%0d exp=%0d", n, f2_a, s2); end
      checks++; if (cnt_a !== 16'(mcnt_a)) begin failures++; $display("FAIL rnd_cnt_a n=%0d got=%0d exp=%0d", n, cnt_a, mcnt_a); end
      predict(hist_b, 1'b0, s1, s2, st);
      checks++; if (stall_b !== st) begin failures++; $display("FAIL rnd_stall_b n=%0d got=%0b exp=%0b", n, stall_b, st); end
      checks++; if (f1_b !== 2'(s1)) begin failures++; $display("FAIL rnd_fwd1_b n=%0d got=%0d exp=%0d", n, f1_b, s1); end
      checks++; if (f2_b !== 2'(s2)) begin failures++; $display("FAIL rnd_fwd2_b n=%0d got=%0d exp=%0d", n, f2_b, s2); end
      checks++; if (cnt_b !== 3'(mcnt_b)) begin failures++; $display("FAIL rnd_cnt_b n=%0d got=%0d exp=%0d", n, cnt_b, mcnt_b); end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      hist_a[i] = '{v: 0, dest: 0, ld: 0};
      hist_b[i] = '{v: 0, dest: 0, ld: 0};
    end
    mcnt_a = 0;
    mcnt_b = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_zero_reg();
    test_flush();
    test_hold();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
